// File: rtl/des_key_sched_ctrl.sv
// DES subkey sequencer: latches a key, then streams round subkeys over valid/ready.
// Optional weak-key flag is compiled in with `define DES_WEAK_KEY_DETECT_EN.

// Combinational DES key schedule: PC-1, cumulative C/D left rotation, PC-2.
module ks (
    input  logic [1:64] key,
    input  logic [4:0]  round,
    output logic [1:48] subkey
);
    localparam int PC1 [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4};

    localparam int PC2 [0:47] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32};

    logic [1:56] cd0;
    logic [1:56] cdRot;
    logic [1:28] cRot;
    logic [1:28] dRot;
    logic [4:0]  shamt;

    for (genvar gi = 0; gi < 56; gi++) begin : gPc1
        localparam int SRC = PC1[gi];
        assign cd0[gi+1] = key[SRC];
    end

    // Total rotation applied by the time round N is reached.
    always_comb begin
        shamt = 5'd0;
        case (round)
            5'd1:  shamt = 5'd1;
            5'd2:  shamt = 5'd2;
            5'd3:  shamt = 5'd4;
            5'd4:  shamt = 5'd6;
            5'd5:  shamt = 5'd8;
            5'd6:  shamt = 5'd10;
            5'd7:  shamt = 5'd12;
            5'd8:  shamt = 5'd14;
            5'd9:  shamt = 5'd15;
            5'd10: shamt = 5'd17;
            5'd11: shamt = 5'd19;
            5'd12: shamt = 5'd21;
            5'd13: shamt = 5'd23;
            5'd14: shamt = 5'd25;
            5'd15: shamt = 5'd27;
            5'd16: shamt = 5'd28;
            default: shamt = 5'd0;
        endcase
    end

    assign cRot  = (cd0[1:28]  << shamt) | (cd0[1:28]  >> (5'd28 - shamt));
    assign dRot  = (cd0[29:56] << shamt) | (cd0[29:56] >> (5'd28 - shamt));
    assign cdRot = {cRot, dRot};

    for (genvar gi = 0; gi < 48; gi++) begin : gPc2
        localparam int SRC = PC2[gi];
        assign subkey[gi+1] = cdRot[SRC];
    end
endmodule

module des_key_sched_ctrl #(
    parameter int NUM_ROUNDS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        decrypt,
    input  logic [1:64] keyIn,
    input  logic        abort,
    output logic        busy,
    output logic [1:48] roundKey,
    output logic        roundKeyValid,
    input  logic        roundKeyReady,
    output logic [4:0]  roundNum,
    output logic        lastRound,
    output logic        done,
    output logic        weakKey
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [4:0] LAST_IDX = 5'(NUM_ROUNDS - 1);
    localparam logic [4:0] FULL_CNT = 5'(NUM_ROUNDS);

    state_t      stateReg, stateNext;
    logic [1:64] keyReg, keyNext;
    logic        decReg, decNext;
    logic [4:0]  roundNumReg, roundNumNext;
    logic [4:0]  xferCntReg, xferCntNext;
    logic [1:48] ksKey;
    logic        xfer;

    ks uKs (
        .key    (keyReg),
        .round  (roundNumReg),
        .subkey (ksKey)
    );

    assign xfer = (stateReg == RUN) && roundKeyReady;

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg    <= IDLE;
            keyReg      <= '0;
            decReg      <= 1'b0;
            roundNumReg <= '0;
            xferCntReg  <= '0;
        end else begin
            stateReg    <= stateNext;
            keyReg      <= keyNext;
            decReg      <= decNext;
            roundNumReg <= roundNumNext;
            xferCntReg  <= xferCntNext;
        end
    end

    always_comb begin
        stateNext    = stateReg;
        keyNext      = keyReg;
        decNext      = decReg;
        roundNumNext = roundNumReg;
        xferCntNext  = xferCntReg;
        case (stateReg)
            IDLE: begin
                if (start) begin
                    keyNext      = keyIn;
                    decNext      = decrypt;
                    roundNumNext = decrypt ? 5'd16 : 5'd1;
                    xferCntNext  = '0;
                    stateNext    = RUN;
                end
            end
            RUN: begin
                // Abort wins over a coincident transfer; that transfer still counts downstream.
                if (abort) begin
                    stateNext    = IDLE;
                    keyNext      = '0;
                    roundNumNext = '0;
                    xferCntNext  = '0;
                end else if (xfer) begin
                    if (xferCntReg == LAST_IDX) begin
                        stateNext    = DONE;
                        roundNumNext = '0;
                        xferCntNext  = FULL_CNT;
                    end else begin
                        xferCntNext = xferCntReg + 5'd1;
                        if (decReg && roundNumReg > 5'd1)
                            roundNumNext = roundNumReg - 5'd1;
                        else if (!decReg && roundNumReg < 5'd16)
                            roundNumNext = roundNumReg + 5'd1;
                    end
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign busy          = (stateReg == RUN) || (stateReg == DONE);
    assign roundKeyValid = (stateReg == RUN);
    assign roundKey      = roundKeyValid ? ksKey : '0;
    assign roundNum      = roundNumReg;
    assign lastRound     = roundKeyValid && (xferCntReg == LAST_IDX);
    assign done          = (stateReg == DONE);

`ifdef DES_WEAK_KEY_DETECT_EN
    logic        weakReg;
    logic [1:64] keyMasked;
    logic        keyIsWeak;

    // Parity bits (LSB of each byte) are don't-care for the weak-key match.
    assign keyMasked = keyIn & 64'hFEFE_FEFE_FEFE_FEFE;
    assign keyIsWeak = (keyMasked == 64'h0000_0000_0000_0000) ||
                       (keyMasked == 64'hFEFE_FEFE_FEFE_FEFE) ||
                       (keyMasked == 64'hE0E0_E0E0_F0F0_F0F0) ||
                       (keyMasked == 64'h1E1E_1E1E_0E0E_0E0E);

    always_ff @(posedge clk) begin
        if (reset)
            weakReg <= 1'b0;
        else if (stateReg == IDLE && start)
            weakReg <= keyIsWeak;
        else if (stateReg == RUN && abort)
            weakReg <= 1'b0;
    end

    assign weakKey = weakReg;
`else
    assign weakKey = 1'b0;
`endif
endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Scoreboard bench for des_key_sched_ctrl: expected subkeys come from an iterative DES key-schedule model.
module tb_des_key_sched_ctrl;
    logic        clk = 1'b0;
    logic        reset, start, start3, decrypt, abort, roundKeyReady;
    logic [63:0] keyIn;
    logic        busy, roundKeyValid, lastRound, done, weakKey;
    logic [47:0] roundKey;
    logic [4:0]  roundNum;
    logic        busy3, valid3, last3, done3, weak3;
    logic [47:0] key3;
    logic [4:0]  num3;

    always #5 clk = ~clk;

    des_key_sched_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .decrypt(decrypt), .keyIn(keyIn),
        .abort(abort), .busy(busy), .roundKey(roundKey), .roundKeyValid(roundKeyValid),
        .roundKeyReady(roundKeyReady), .roundNum(roundNum), .lastRound(lastRound),
        .done(done), .weakKey(weakKey)
    );

    des_key_sched_ctrl #(.NUM_ROUNDS(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .decrypt(decrypt), .keyIn(keyIn),
        .abort(abort), .busy(busy3), .roundKey(key3), .roundKeyValid(valid3),
        .roundKeyReady(roundKeyReady), .roundNum(num3), .lastRound(last3),
        .done(done3), .weakKey(weak3)
    );

`ifdef DES_WEAK_KEY_DETECT_EN
    localparam bit WEAK_EN = 1'b1;
`else
    localparam bit WEAK_EN = 1'b0;
`endif

    localparam logic [63:0] KEY = 64'h1334_5779_9BBC_DFF1;

    localparam int PC1_T [0:55] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
        10,2,59,51,43,35,27, 19,11,3,60,52,44,36, 63,55,47,39,31,23,15,
        7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2_T [0:47] = '{14,17,11,24,1,5, 3,28,15,6,21,10,
        23,19,12,4,26,8, 16,7,27,20,13,2, 41,52,31,37,47,55,
        30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int SH_T [0:15] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    typedef struct packed {
        logic [4:0]  num;
        logic [47:0] key;
    } exp_t;

    exp_t        expQ[$];
    int          checkCnt = 0;
    int          errCnt = 0;
    int          popCnt = 0;
    int          stuck = 0;
    int          phase = 0;
    logic [47:0] lastPopKey = '0;
    logic [4:0]  lastPopNum = '0;
    logic        prevValid = 1'b0, prevReady = 1'b0;
    logic [47:0] prevKey = '0;
    logic [4:0]  prevNum = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Shifts C and D one bit at a time, round by round.
    function automatic logic [47:0] refKey(input logic [63:0] k, input int rnd);
        logic [27:0] c, d;
        logic [47:0] r;
        int p;
        for (int i = 0; i < 28; i++) begin
            c[27-i] = k[64-PC1_T[i]];
            d[27-i] = k[64-PC1_T[i+28]];
        end
        for (int s = 0; s < rnd; s++)
            for (int t = 0; t < SH_T[s]; t++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
        for (int i = 0; i < 48; i++) begin
            p = PC2_T[i];
            r[47-i] = (p <= 28) ? c[28-p] : d[56-p];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startRun(input logic [63:0] k, input logic dec);
        exp_t e;
        int r;
        keyIn   = k;
        decrypt = dec;
        start   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            r = dec ? 16 - i : 1 + i;
            e.num = 5'(r);
            e.key = refKey(k, r);
            expQ.push_back(e);
        end
        tick();
        start = 1'b0;
        keyIn = {$urandom, $urandom};
    endtask

    // mode 0: ready held high; mode 1: 1,0,0 pattern with a 5-cycle stall at round 7.
    task automatic runUntilDone(input int mode, output int cyc, output int vCnt);
        cyc  = 0;
        vCnt = 0;
        while (!done && cyc < 400) begin
            if (mode == 1) begin
                if (roundKeyValid && roundNum == 5'd7 && stuck < 5) begin
                    roundKeyReady = 1'b0;
                    stuck++;
                end else begin
                    roundKeyReady = (phase % 3 == 0);
                end
                phase++;
            end
            if (roundKeyValid) vCnt++;
            tick();
            cyc++;
        end
        check("done_seen", done, 1);
        check("done_valid_low", roundKeyValid, 0);
        check("done_busy", busy, 1);
        check("done_num_zero", roundNum, 0);
        roundKeyReady = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (roundKeyValid && prevValid && !prevReady) begin
            check("stall_key", roundKey, prevKey);
            check("stall_num", roundNum, prevNum);
        end
        if (roundKeyValid && roundKeyReady) begin
            check("xfer_queued", expQ.size() > 0, 1);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                check("xfer_num", roundNum, e.num);
                check("xfer_key", roundKey, e.key);
                check("xfer_last", lastRound, expQ.size() == 0);
                popCnt++;
                lastPopKey = roundKey;
                lastPopNum = roundNum;
                $display("xfer round %0d key %h last %0d", roundNum, roundKey, lastRound);
            end
        end
        prevValid = roundKeyValid;
        prevReady = roundKeyReady;
        prevKey   = roundKey;
        prevNum   = roundNum;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, vCnt, n;
        logic [63:0] wkeys [0:2];
        logic        wexp  [0:2];

        reset = 1'b1; start = 1'b0; start3 = 1'b0; decrypt = 1'b0;
        abort = 1'b0; roundKeyReady = 1'b0; keyIn = '0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_valid", roundKeyValid, 0);
        check("rst_key", roundKey, 0);
        check("rst_num", roundNum, 0);
        check("rst_last", lastRound, 0);
        check("rst_done", done, 0);
        check("rst_weak", weakKey, 0);
        check("rst_busy3", busy3, 0);
        reset = 1'b0;
        tick();

        // Encrypt, ready held high
        roundKeyReady = 1'b1;
        popCnt = 0;
        startRun(KEY, 1'b0);
        check("enc_first_valid", roundKeyValid, 1);
        check("enc_K1", roundKey, 48'h1B02EFFC7072);
        check("enc_num1", roundNum, 1);
        tick();
        check("enc_K2", roundKey, 48'h79AED9DBC9E5);
        runUntilDone(0, cyc, vCnt);
        check("enc_valid_cycles", 1 + vCnt, 16);
        check("enc_done_latency", 1 + cyc, 16);
        check("enc_K16", lastPopKey, 48'hCB3D8B0E17F5);
        tick();
        check("enc_done_pulse", done, 0);
        check("enc_busy_drop", busy, 0);
        check("enc_pops", popCnt, 16);

        // Decrypt
        popCnt = 0;
        startRun(KEY, 1'b1);
        check("dec_first_key", roundKey, 48'hCB3D8B0E17F5);
        check("dec_first_num", roundNum, 16);
        runUntilDone(0, cyc, vCnt);
        check("dec_last_key", lastPopKey, 48'h1B02EFFC7072);
        check("dec_last_num", lastPopNum, 1);
        check("dec_pops", popCnt, 16);
        tick();
        check("dec_busy_drop", busy, 0);

        // Backpressure
        popCnt = 0; stuck = 0; phase = 0;
        roundKeyReady = 1'b0;
        startRun(KEY, 1'b0);
        runUntilDone(1, cyc, vCnt);
        check("bp_pops", popCnt, 16);
        check("bp_stuck", stuck, 5);
        check("bp_queue_empty", expQ.size(), 0);
        tick();

        // Abort coincident with round-5 transfer
        popCnt = 0;
        roundKeyReady = 1'b1;
        startRun(KEY, 1'b0);
        n = 0;
        while (roundNum != 5'd5 && n < 40) begin tick(); n++; end
        check("abort_reach5", roundNum, 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", roundKeyValid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_num", roundNum, 0);
        check("abort_pops", popCnt, 5);
        expQ.delete();
        tick();
        check("abort_no_done", done, 0);
        check("abort_no_valid", roundKeyValid, 0);
        popCnt = 0;
        startRun(KEY, 1'b0);
        check("restart_num", roundNum, 1);
        check("restart_key", roundKey, 48'h1B02EFFC7072);
        runUntilDone(0, cyc, vCnt);
        check("restart_pops", popCnt, 16);
        tick();

        // start re-asserted during RUN and DONE with a different key
        popCnt = 0;
        startRun(KEY, 1'b0);
        start = 1'b1; keyIn = 64'h0123_4567_89AB_CDEF; decrypt = 1'b1;
        runUntilDone(0, cyc, vCnt);
        tick();
        start = 1'b0; decrypt = 1'b0;
        check("start_in_done_ignored", busy, 0);
        tick();
        check("start_idle_busy", busy, 0);
        check("start_idle_valid", roundKeyValid, 0);
        check("start_pops", popCnt, 16);

        // Reset at round 9
        startRun(KEY, 1'b0);
        n = 0;
        while (roundNum != 5'd9 && n < 40) begin tick(); n++; end
        check("rst9_reach", roundNum, 9);
        roundKeyReady = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst9_busy", busy, 0);
        check("rst9_valid", roundKeyValid, 0);
        check("rst9_key", roundKey, 0);
        check("rst9_num", roundNum, 0);
        check("rst9_last", lastRound, 0);
        check("rst9_done", done, 0);
        expQ.delete();
        tick();

        // NUM_ROUNDS=3 instance
        roundKeyReady = 1'b1; keyIn = KEY; decrypt = 1'b0;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int r = 1; r <= 3; r++) begin
            check("n3_valid", valid3, 1);
            check("n3_num", num3, 5'(r));
            check("n3_key", key3, refKey(KEY, r));
            check("n3_last", last3, r == 3);
            tick();
        end
        check("n3_done", done3, 1);
        check("n3_valid_low", valid3, 0);
        tick();
        check("n3_busy_drop", busy3, 0);

        // Weak-key flag
        wkeys[0] = 64'h0; wkeys[1] = 64'hFEFE_FEFE_FEFE_FEFE; wkeys[2] = KEY;
        wexp[0] = WEAK_EN; wexp[1] = WEAK_EN; wexp[2] = 1'b0;
        roundKeyReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            startRun(wkeys[i], 1'b0);
            check("weak_flag", weakKey, wexp[i]);
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check("weak_cleared", weakKey, 0);
            expQ.delete();
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
        $finish;
    end
endmodule
